step_counter: RTL
=================

# step_counter

Parametrised, registered step counter that generalises the combinational incrementer into a clocked datapath component. It adds a programmable step, up/down direction, a programmable upper limit, and wrap, saturate and one-shot modes. It also provides a terminal-count pulse and a sticky overflow flag. It sits in the datapath library alongside REG and INC, and is used wherever a loop index, address or event count must advance by more than one per cycle.

## Interface
- DATAWIDTH, 8, width of count, limit and load value
- STEPWIDTH, 4, width of step input (STEPWIDTH ≤ DATAWIDTH)
- Clk  in  1  rising-edge clock; the only clock
- Rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear
- load  in  1  synchronous load of ld_val
- ld_val  in  DATAWIDTH  load value
- en  in  1  advance count by step this cycle
- dir  in  1  0 = up, 1 = down
- step  in  STEPWIDTH  unsigned increment, zero-extended
- limit  in  DATAWIDTH  upper bound; the lower bound is always 0
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- d  out  DATAWIDTH  registered count
- tc  out  1  one-cycle terminal-count pulse
- ovf  out  1  sticky wrap flag
- halted  out  1  one-shot has reached its bound

## Operation
- Priority per cycle: Rst > clr > load > en (en ignored while halted).
- clr: d←0, ovf←0, state←RUN, tc←0.
- load: d←min(ld_val, limit), state←RUN, tc←0, ovf unchanged.
- Arithmetic is computed at DATAWIDTH+1 bits, with no silent truncation.
- Bound is limit for up and 0 for down.
- Up step: sum = d + step.
  - sum < limit: d←sum.
  - sum = limit: d←limit, tc←1.
  - sum > limit (crossing):
    - wrap: d←sum−limit−1 (d←0 if that still exceeds limit), tc←1, ovf←1.
    - saturate: d←limit, tc←1.
    - one-shot: d←limit, tc←1, state←HALT.
- Down step:
  - d > step: d←d−step.
  - d = step: d←0, tc←1.
  - d < step (crossing):
    - wrap: d←limit−(step−d−1) (d←0 if step−d−1 > limit), tc←1, ovf←1.
    - saturate: d←0, tc←1.
    - one-shot: d←0, tc←1, state←HALT.
- One-shot that lands exactly on its bound also enters HALT.
- step = 0: d unchanged, tc←0.
- Saturate already at bound with en: d holds, tc←0 (tc marks arrival only).
- d > limit after limit is lowered: the next up step is a crossing; down steps subtract normally.
- State machine: RUN → HALT (one-shot reaches bound); HALT → RUN (load or clr only); Rst → RUN.
- halted = (state == HALT).

## Timing
- All outputs are registered; one-cycle latency from en/load/clr to d, tc and ovf.
- tc is high for exactly one cycle per qualifying step; back-to-back qualifying steps give tc high on consecutive cycles.
- Reset values: d=0, tc=0, ovf=0, halted=0, state=RUN. They apply asynchronously on Rst rise.
- Rst asserted mid-count clears within the same cycle, with no dependence on Clk. The first step after release is taken on the first Clk edge where Rst is low.
- Inputs are sampled on the rising Clk edge only; no combinational path from inputs to outputs.

## Structure
- Shared package/include step_counter_pkg holds:
  - MODE_WRAP, MODE_SAT, MODE_ONESHOT (2'b11 aliases wrap)
  - ST_RUN, ST_HALT encodings
- Sub-module step_counter_nxt is purely combinational.
  - Inputs: d, step, dir, limit, mode.
  - Outputs: next value, hit (reached/crossed bound), wrap.
  - It is the generalised incrementer.
- The top level holds the registers, priority mux and state machine.

## Test plan
Unless noted, DATAWIDTH=8.
- Async reset: count at d=37, raise Rst between edges -> d=0, tc=0, ovf=0, halted=0 before the next edge.
- Wrap up, limit=9, step=3:
  - d=6, en -> d=9, tc=1, ovf=0
  - next en -> d=2, tc=1, ovf=1
  - next en -> d=5, tc=0, ovf stays 1
- Wrap down, limit=9, dir=1, step=3, d=1, en -> d=8, tc=1, ovf=1.
- Saturate down, limit=200, step=5, d=2, dir=1:
  - en -> d=0, tc=1
  - en again -> d=0, tc=0
- One-shot up, limit=20, step=4, d=18:
  - en -> d=20, tc=1, halted=1
  - 3 further en -> d=20, tc=0
  - load ld_val=250 -> d=20 (clipped), halted=0
- Priority: clr, load and en all high with ovf=1, d=7 -> d=0, ovf=0, tc=0. Then load alone with en, ld_val=4 -> d=4 (load beats en).

Source files
------------

// File: rtl/step_counter_pkg.sv
// Shared encodings for the step counter: counting modes and run/halt states.
package step_counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP     = 2'b00,
      MODE_SAT      = 2'b01,
      MODE_ONESHOT  = 2'b10,
      MODE_WRAP_ALT = 2'b11
   } mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   // The spare encoding behaves exactly like wrap.
   function automatic logic mode_is_wrap(input mode_e m);
      return (m == MODE_WRAP) || (m == MODE_WRAP_ALT);
   endfunction

   function automatic logic mode_is_sat(input mode_e m);
      return (m == MODE_SAT);
   endfunction

   function automatic logic mode_is_oneshot(input mode_e m);
      return (m == MODE_ONESHOT);
   endfunction

endpackage

// File: rtl/step_counter_if.sv
// Control/status bundle of the step counter; master drives controls, slave is the counter.
interface step_counter_if #(
   parameter int DATAWIDTH = 8,
   parameter int STEPWIDTH = 4
) ();

   logic                 clr;
   logic                 load;
   logic [DATAWIDTH-1:0] ld_val;
   logic                 en;
   logic                 dir;
   logic [STEPWIDTH-1:0] step;
   logic [DATAWIDTH-1:0] limit;
   logic [1:0]           mode;
   logic [DATAWIDTH-1:0] d;
   logic                 tc;
   logic                 ovf;
   logic                 halted;

   modport master (
      output clr, load, ld_val, en, dir, step, limit, mode,
      input  d, tc, ovf, halted
   );

   modport slave (
      input  clr, load, ld_val, en, dir, step, limit, mode,
      output d, tc, ovf, halted
   );

endinterface

// File: rtl/step_counter_nxt.sv
// Combinational generalised incrementer: next count for one step, bound hit and wrap flags.
// Zero latency; no handshake, result is valid whenever the inputs are.
module step_counter_nxt
   import step_counter_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int STEPWIDTH = 4
) (
   input  logic [DATAWIDTH-1:0] d,
   input  logic [STEPWIDTH-1:0] step,
   input  logic                 dir,
   input  logic [DATAWIDTH-1:0] limit,
   input  mode_e                mode,
   output logic [DATAWIDTH-1:0] nxt,
   output logic                 hit,
   output logic                 wrap
);

   localparam int XW = DATAWIDTH + 1;

   logic [XW-1:0]        d_x;
   logic [XW-1:0]        s_x;
   logic [XW-1:0]        l_x;
   logic [XW-1:0]        sum;
   logic [XW-1:0]        up_rem;
   logic [XW-1:0]        dn_rem;
   logic [DATAWIDTH-1:0] diff;
   logic                 at_bound;

   always_comb begin
      d_x      = {1'b0, d};
      s_x      = XW'(step);
      l_x      = {1'b0, limit};
      sum      = d_x + s_x;
      up_rem   = sum - l_x - XW'(1);
      dn_rem   = s_x - d_x - XW'(1);
      diff     = d - DATAWIDTH'(step);
      at_bound = dir ? (d == '0) : (d == limit);

      nxt  = d;
      hit  = 1'b0;
      wrap = 1'b0;

      // A zero step, or saturate resting on its bound, is a no-op: tc marks arrival only.
      if (step == '0) begin
         nxt = d;
      end else if (mode_is_sat(mode) && at_bound) begin
         nxt = d;
      end else if (!dir) begin
         if (sum < l_x) begin
            nxt = sum[DATAWIDTH-1:0];
         end else if (sum == l_x) begin
            nxt = limit;
            hit = 1'b1;
         end else begin
            hit = 1'b1;
            if (mode_is_wrap(mode)) begin
               wrap = 1'b1;
               nxt  = (up_rem > l_x) ? '0 : up_rem[DATAWIDTH-1:0];
            end else begin
               nxt = limit;
            end
         end
      end else begin
         if (d_x > s_x) begin
            nxt = diff;
         end else if (d_x == s_x) begin
            nxt = '0;
            hit = 1'b1;
         end else begin
            hit = 1'b1;
            if (mode_is_wrap(mode)) begin
               wrap = 1'b1;
               nxt  = (dn_rem > l_x) ? '0 : (limit - dn_rem[DATAWIDTH-1:0]);
            end else begin
               nxt = '0;
            end
         end
      end
   end

endmodule

// File: rtl/step_counter.sv
// Registered step counter: clr > load > en priority, one-cycle latency to d/tc/ovf/halted.
// No backpressure; an en while halted is dropped until the next load or clr.
module step_counter
   import step_counter_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int STEPWIDTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   step_counter_if.slave bus
);

   logic [DATAWIDTH-1:0] d_q;
   logic [DATAWIDTH-1:0] d_n;
   logic                 tc_q;
   logic                 tc_n;
   logic                 ovf_q;
   logic                 ovf_n;
   state_e               state_q;
   state_e               state_n;

   mode_e                mode;
   logic [DATAWIDTH-1:0] ld_clip;
   logic [DATAWIDTH-1:0] step_nxt;
   logic                 step_hit;
   logic                 step_wrap;

   assign mode    = mode_e'(bus.mode);
   assign ld_clip = (bus.ld_val > bus.limit) ? bus.limit : bus.ld_val;

   step_counter_nxt #(
      .DATAWIDTH (DATAWIDTH),
      .STEPWIDTH (STEPWIDTH)
   ) u_nxt (
      .d     (d_q),
      .step  (bus.step),
      .dir   (bus.dir),
      .limit (bus.limit),
      .mode  (mode),
      .nxt   (step_nxt),
      .hit   (step_hit),
      .wrap  (step_wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q     <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         state_q <= ST_RUN;
      end else begin
         d_q     <= d_n;
         tc_q    <= tc_n;
         ovf_q   <= ovf_n;
         state_q <= state_n;
      end
   end

   always_comb begin
      d_n     = d_q;
      tc_n    = 1'b0;
      ovf_n   = ovf_q;
      state_n = state_q;

      if (bus.clr) begin
         d_n     = '0;
         ovf_n   = 1'b0;
         state_n = ST_RUN;
      end else if (bus.load) begin
         d_n     = ld_clip;
         state_n = ST_RUN;
      end else if (bus.en && (state_q == ST_RUN)) begin
         d_n   = step_nxt;
         tc_n  = step_hit;
         ovf_n = ovf_q | step_wrap;
         if (mode_is_oneshot(mode) && step_hit) begin
            state_n = ST_HALT;
         end
      end
   end

   assign bus.d      = d_q;
   assign bus.tc     = tc_q;
   assign bus.ovf    = ovf_q;
   assign bus.halted = (state_q == ST_HALT);

endmodule
